// File: rtl/increment_16.sv
// rtl/increment_16.sv - 16-bit incrementer with block lookahead carry and registered copy
module increment_16 (
    output logic [15:0] out,
    input  logic [15:0] in,
    input  logic        clk,
    input  logic        rst_n,
    output logic        cout,
    output logic [15:0] out_q,
    output logic        cout_q
);

    logic [3:0]  blk_p;
    logic [3:0]  blk_cin;
    logic [15:0] sum;
    logic [15:0] out_d;
    logic        cout_d;

    // A block propagates the incoming carry only when all four of its bits are ones.
    assign blk_p[0] = &in[3:0];
    assign blk_p[1] = &in[7:4];
    assign blk_p[2] = &in[11:8];
    assign blk_p[3] = &in[15:12];

    // Constant carry-in of 1 enters block 0; higher blocks look ahead over all lower ones.
    assign blk_cin[0] = 1'b1;
    assign blk_cin[1] = blk_p[0];
    assign blk_cin[2] = blk_p[0] & blk_p[1];
    assign blk_cin[3] = blk_p[0] & blk_p[1] & blk_p[2];

    always_comb begin
        logic c;
        c   = 1'b0;
        sum = '0;
        for (int b = 0; b < 4; b++) begin
            c = blk_cin[b];
            for (int j = 0; j < 4; j++) begin
                sum[4*b+j] = in[4*b+j] ^ c;
                c          = c & in[4*b+j];
            end
        end
    end

    assign out  = sum;
    assign cout = &blk_p;

    always_comb begin
        out_d  = out;
        cout_d = cout;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= 16'h0000;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
        end
    end

endmodule

// File: tb/tb_increment_16.sv
// tb/tb_increment_16.sv - self-checking bench for increment_16
module tb_increment_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_v;
    logic [15:0] out_v;
    logic        cout_v;
    logic [15:0] out_q_v;
    logic        cout_q_v;

    int pass_cnt;
    int total_cnt;

    increment_16 dut (
        .out    (out_v),
        .in     (in_v),
        .clk    (clk),
        .rst_n  (rst_n),
        .cout   (cout_v),
        .out_q  (out_q_v),
        .cout_q (cout_q_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] model_inc(input logic [15:0] v);
        return {1'b0, v} + 17'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] e;
        rst_n = 1'b0;
        in_v  = 16'h1858;
        tick();
        tick();
        e = model_inc(in_v);
        total_cnt++;
        if (out_q_v !== 16'h0000) $display("FAIL reset_out_q got %h want 0000", out_q_v);
        else pass_cnt++;
        total_cnt++;
        if (cout_q_v !== 1'b0) $display("FAIL reset_cout_q got %b want 0", cout_q_v);
        else pass_cnt++;
        total_cnt++;
        if (out_v !== e[15:0] || cout_v !== e[16])
            $display("FAIL reset_comb got %h/%b want %h/%b", out_v, cout_v, e[15:0], e[16]);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (out_q_v !== e[15:0] || cout_q_v !== e[16])
            $display("FAIL release_capture got %h/%b want %h/%b", out_q_v, cout_q_v, e[15:0], e[16]);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [15:0] vec [7];
        logic [16:0] e;
        vec = '{16'h0000, 16'h00FD, 16'h000F, 16'h00FF, 16'h0FFF, 16'h7FFF, 16'hFFFF};
        foreach (vec[i]) begin
            in_v = vec[i];
            #1;
            e = model_inc(vec[i]);
            total_cnt++;
            if (out_v !== e[15:0] || cout_v !== e[16])
                $display("FAIL directed_%h got %h/%b want %h/%b", vec[i], out_v, cout_v, e[15:0], e[16]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [16:0] e;
        for (int i = 0; i < 34; i++) begin
            if (i == 0) v = 16'h0A9D;
            else if (i == 1) v = 16'hE467;
            else v = 16'($urandom);
            in_v = v;
            #1;
            e = model_inc(v);
            total_cnt++;
            if (out_v !== e[15:0] || cout_v !== e[16])
                $display("FAIL random_%h got %h/%b want %h/%b", v, out_v, cout_v, e[15:0], e[16]);
            else pass_cnt++;
        end
    endtask

    task automatic test_registered();
        logic [16:0] e;
        for (int i = 0; i < 12; i++) begin
            in_v = 16'($urandom);
            e    = model_inc(in_v);
            tick();
            total_cnt++;
            if (out_q_v !== e[15:0] || cout_q_v !== e[16])
                $display("FAIL pipe_%0d got %h/%b want %h/%b", i, out_q_v, cout_q_v, e[15:0], e[16]);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        in_v = 16'hFFFF;
        tick();
        total_cnt++;
        if (out_q_v !== 16'h0000 || cout_q_v !== 1'b1)
            $display("FAIL wrap_registered got %h/%b want 0000/1", out_q_v, cout_q_v);
        else pass_cnt++;
        rst_n = 1'b0;
        in_v  = 16'h1234;
        tick();
        total_cnt++;
        if (out_q_v !== 16'h0000 || cout_q_v !== 1'b0)
            $display("FAIL midstream_reset got %h/%b want 0000/0", out_q_v, cout_q_v);
        else pass_cnt++;
        total_cnt++;
        if (out_v !== 16'h1235 || cout_v !== 1'b0)
            $display("FAIL midstream_comb got %h/%b want 1235/0", out_v, cout_v);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (out_q_v !== 16'h1235 || cout_q_v !== 1'b0)
            $display("FAIL rerelease got %h/%b want 1235/0", out_q_v, cout_q_v);
        else pass_cnt++;
    endtask

    task automatic test_exhaustive();
        int errs;
        int cout_hits;
        logic [16:0] e;
        errs      = 0;
        cout_hits = 0;
        for (int v = 0; v < 65536; v++) begin
            in_v = 16'(v);
            #1;
            e = model_inc(16'(v));
            if (cout_v === 1'b1) cout_hits++;
            if (out_v !== e[15:0] || cout_v !== e[16]) begin
                if (errs < 5)
                    $display("FAIL exhaustive_%h got %h/%b want %h/%b", 16'(v), out_v, cout_v, e[15:0], e[16]);
                errs++;
            end
        end
        total_cnt++;
        if (errs != 0) $display("FAIL exhaustive_count got %0d errors want 0", errs);
        else pass_cnt++;
        total_cnt++;
        if (cout_hits != 1) $display("FAIL exhaustive_cout_hits got %0d want 1", cout_hits);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        in_v      = 16'h0000;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_registered();
        test_wrap();
        test_exhaustive();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
